// File: rtl/clk_burst_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_burst_pkg
// Shared types and constants for the clock-burst generator.
//   state_t     : burst FSM states (IDLE, LOW, HIGH, DONE)
//   IDLE_LEVEL  : level clk_out parks at whenever no burst is running
//   HP_W_DEF    : default width of the half-period field
//   CNT_W_DEF   : default width of the edge-count fields
// -----------------------------------------------------------------------------
package clk_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam int HP_W_DEF  = 8;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/clk_burst_gen_if.sv
// -----------------------------------------------------------------------------
// clk_burst_gen_if
// Control/status bundle of the clock-burst generator (rdclk domain).
//   en, start, abort         : control from the requester
//   half_period, n_edges     : burst shape, sampled when a start is accepted
//   clk_out, busy, done,
//   edge_cnt                 : generated clock and status back to the requester
// Modports: master = requester side, slave = generator side.
// -----------------------------------------------------------------------------
interface clk_burst_gen_if
  import clk_burst_pkg::*;
#(
  parameter int HP_W  = HP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             en;
  logic             start;
  logic             abort;
  logic [HP_W-1:0]  half_period;
  logic [CNT_W-1:0] n_edges;
  logic             clk_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output en, start, abort, half_period, n_edges,
    input  clk_out, busy, done, edge_cnt
  );

  modport slave (
    input  en, start, abort, half_period, n_edges,
    output clk_out, busy, done, edge_cnt
  );

endinterface

// File: rtl/clk_burst_gen_phase_timer.sv
// -----------------------------------------------------------------------------
// clk_burst_gen_phase_timer
// Down-counter that measures one level of the burst clock.
//   rdclk     in   clock
//   reset     in   asynchronous active-high reset
//   en        in   count enable; low freezes the count
//   load      in   load load_val (takes priority over counting)
//   load_val  in   HP_W  cycles-per-level minus one
//   expire    out  high on the last cycle of the current level
// -----------------------------------------------------------------------------
module clk_burst_gen_phase_timer #(
  parameter int HP_W = 8
) (
  input  logic            rdclk,
  input  logic            reset,
  input  logic            en,
  input  logic            load,
  input  logic [HP_W-1:0] load_val,
  output logic            expire
);

  logic [HP_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loaded with hp-1 on level entry, so zero marks the hp-th cycle.
  assign expire = (cnt == '0);

endmodule

// File: rtl/clk_burst_gen.sv
// -----------------------------------------------------------------------------
// clk_burst_gen
// Programmable clock-burst generator: emits n_edges falling edges on clk_out,
// each level half_period enabled cycles long, then parks high and pulses done.
//   rdclk   in   sole clock
//   reset   in   asynchronous active-high reset
//   bus     slave modport of clk_burst_gen_if (control, shape, status)
// -----------------------------------------------------------------------------
module clk_burst_gen
  import clk_burst_pkg::*;
#(
  parameter int HP_W  = HP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            rdclk,
  input  logic            reset,
  clk_burst_gen_if.slave  bus
);

  state_t           state_q, state_nx;
  logic             clk_out_q, clk_out_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_nx;
  logic [HP_W-1:0]  hp_q, hp_nx;
  logic [CNT_W-1:0] n_q, n_nx;

  logic             tmr_load;
  logic [HP_W-1:0]  tmr_val;
  logic             tmr_expire;
  logic [HP_W-1:0]  hp_sel;

  // A zero half period would give a degenerate level; run it as one cycle.
  assign hp_sel = (bus.half_period == '0) ? HP_W'(1) : bus.half_period;

  clk_burst_gen_phase_timer #(.HP_W(HP_W)) u_timer (
    .rdclk    (rdclk),
    .reset    (reset),
    .en       (bus.en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_out_q  <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edge_cnt_q <= '0;
      hp_q       <= '0;
      n_q        <= '0;
    end else begin
      state_q    <= state_nx;
      clk_out_q  <= clk_out_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
      edge_cnt_q <= edge_cnt_nx;
      hp_q       <= hp_nx;
      n_q        <= n_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold/default value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_nx    = state_q;
    clk_out_nx  = clk_out_q;
    busy_nx     = busy_q;
    done_nx     = done_q;
    edge_cnt_nx = edge_cnt_q;
    hp_nx       = hp_q;
    n_nx        = n_q;
    tmr_load    = 1'b0;
    tmr_val     = hp_q - 1'b1;

    if (bus.abort) begin
      // Cancel bypasses the enable; edge_cnt keeps the partial count.
      state_nx   = IDLE;
      clk_out_nx = IDLE_LEVEL;
      busy_nx    = 1'b0;
      done_nx    = 1'b0;
    end else if (bus.en) begin
      done_nx = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            hp_nx = hp_sel;
            n_nx  = bus.n_edges;
            if (bus.n_edges != '0) begin
              state_nx    = LOW;
              clk_out_nx  = 1'b0;
              busy_nx     = 1'b1;
              edge_cnt_nx = CNT_W'(1);
              tmr_load    = 1'b1;
              tmr_val     = hp_sel - 1'b1;
            end else begin
              state_nx    = DONE;
              edge_cnt_nx = '0;
              done_nx     = 1'b1;
            end
          end
        end
        LOW: begin
          if (tmr_expire) begin
            state_nx   = HIGH;
            clk_out_nx = 1'b1;
            tmr_load   = 1'b1;
          end
        end
        HIGH: begin
          if (tmr_expire) begin
            if (edge_cnt_q == n_q) begin
              state_nx   = DONE;
              clk_out_nx = IDLE_LEVEL;
              busy_nx    = 1'b0;
              done_nx    = 1'b1;
            end else begin
              state_nx    = LOW;
              clk_out_nx  = 1'b0;
              edge_cnt_nx = edge_cnt_q + 1'b1;
              tmr_load    = 1'b1;
            end
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_clk_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_burst_gen
// Directed bench for clk_burst_gen. Cycle numbers count rdclk edges after the
// edge that accepted start; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_clk_burst_gen;

  logic rdclk = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  clk_burst_gen_if #(.HP_W(8), .CNT_W(8)) bus ();

  clk_burst_gen #(.HP_W(8), .CNT_W(8)) dut (
    .rdclk (rdclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 rdclk = ~rdclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic launch(input logic [7:0] hp, input logic [7:0] n);
    bus.half_period = hp;
    bus.n_edges     = n;
    bus.start       = 1'b1;
  endtask

  initial begin
    bus.en          = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.half_period = '0;
    bus.n_edges     = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: reset state held through 20 idle cycles
    for (int c = 0; c < 20; c++) begin
      check($sformatf("t1 clk c%0d", c), bus.clk_out, 1);
      check($sformatf("t1 busy c%0d", c), bus.busy, 0);
      check($sformatf("t1 done c%0d", c), bus.done, 0);
      check($sformatf("t1 ecnt c%0d", c), bus.edge_cnt, 0);
      tick();
    end

    // 2: hp=2, n=3 -> levels of 2, done at 13
    launch(8'd2, 8'd3);
    for (int c = 1; c <= 14; c++) begin
      tick();
      bus.start = 1'b0;
      if (c == 3) bus.half_period = 8'd7;  // mid-burst change must not matter
      check($sformatf("t2 clk c%0d", c), bus.clk_out,
            (c <= 12) ? (((c - 1) / 2) % 2) : 1);
      check($sformatf("t2 done c%0d", c), bus.done, (c == 13) ? 1 : 0);
      check($sformatf("t2 busy c%0d", c), bus.busy, (c <= 12) ? 1 : 0);
    end
    check("t2 ecnt", bus.edge_cnt, 3);
    tick();

    // 3: hp=0 runs as hp=1
    launch(8'd0, 8'd1);
    tick(); bus.start = 1'b0;
    check("t3 clk c1", bus.clk_out, 0);
    check("t3 ecnt c1", bus.edge_cnt, 1);
    tick();
    check("t3 clk c2", bus.clk_out, 1);
    check("t3 done c2", bus.done, 0);
    tick();
    check("t3 done c3", bus.done, 1);
    check("t3 busy c3", bus.busy, 0);
    tick();
    check("t3 done c4", bus.done, 0);

    // 4: n=0 -> no edge, done at 1
    launch(8'd4, 8'd0);
    tick(); bus.start = 1'b0;
    check("t4 done c1", bus.done, 1);
    check("t4 busy c1", bus.busy, 0);
    check("t4 clk c1", bus.clk_out, 1);
    check("t4 ecnt c1", bus.edge_cnt, 0);
    tick();
    check("t4 done c2", bus.done, 0);
    check("t4 busy c2", bus.busy, 0);
    tick();

    // 5: hp=3, n=4, en low for 5 edges during the first LOW level
    launch(8'd3, 8'd4);
    for (int c = 1; c <= 31; c++) begin
      tick();
      bus.start = 1'b0;
      if (c == 2) bus.en = 1'b0;
      if (c == 7) bus.en = 1'b1;
      if (c <= 11)
        check($sformatf("t5 clk c%0d", c), bus.clk_out, (c <= 8) ? 0 : 1);
      if (c == 5) check("t5 ecnt stall", bus.edge_cnt, 1);
      if (c == 29) check("t5 busy c29", bus.busy, 1);
      if (c == 30) check("t5 busy c30", bus.busy, 0);
      check($sformatf("t5 done c%0d", c), bus.done, (c == 30) ? 1 : 0);
    end
    check("t5 ecnt", bus.edge_cnt, 4);

    // 6: abort mid-burst (start also high), restart, then async reset
    launch(8'd2, 8'd5);
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.start = 1'b0;
    end
    check("t6 clk c6", bus.clk_out, 0);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t6 clk c7", bus.clk_out, 1);
    check("t6 busy c7", bus.busy, 0);
    check("t6 done c7", bus.done, 0);
    check("t6 ecnt c7", bus.edge_cnt, 2);
    tick();
    bus.start = 1'b0;
    check("t6 clk c8", bus.clk_out, 0);
    check("t6 busy c8", bus.busy, 1);
    check("t6 done c8", bus.done, 0);
    check("t6 ecnt c8", bus.edge_cnt, 1);
    tick();
    check("t6 clk c9", bus.clk_out, 0);
    #2 reset = 1'b1;
    #1;
    check("t6 rst clk", bus.clk_out, 1);
    check("t6 rst busy", bus.busy, 0);
    check("t6 rst ecnt", bus.edge_cnt, 0);
    tick();
    reset = 1'b0;

    // abort and start together in IDLE: abort wins
    bus.abort = 1'b1;
    launch(8'd1, 8'd2);
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("t7 busy", bus.busy, 0);
    check("t7 clk", bus.clk_out, 1);
    tick();
    check("t7 busy later", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
